// File: rtl/branch_condition_unit.sv
//------------------------------------------------------------------------------
// branch_condition_unit
//
// Purpose:
//   Resolves SPARC Bicc conditional branches sitting in the ID stage. It
//   evaluates the branch condition on the integer condition codes, forwarding
//   the icc value from EX when the EX instruction is writing the flags. It
//   computes the PC-relative branch target. A small FSM tracks the delay slot
//   and marks an annulled delay slot so that it can be squashed.
//   Every output is a register, so no path runs from an input to an output.
//
// Ports:
//   clk        in   1   clock; all state updates on the rising edge
//   clr        in   1   synchronous active-high reset (beats stall)
//   stall      in   1   pipeline hold; all registers keep their value
//   id_is_bicc in   1   ID instruction is a Bicc
//   id_cond    in   4   Bicc cond field
//   id_annul   in   1   Bicc annul (a) bit
//   id_disp22  in  22   word displacement of the branch
//   id_pc      in  32   PC of the ID instruction
//   psr_icc    in   4   PSR flags {Z, C, N, V}
//   ex_setcc   in   1   EX instruction writes icc this cycle
//   ex_icc     in   4   icc produced in EX {Z, C, N, V}
//   taken_q    out  1   branch taken, one cycle after acceptance
//   target_q   out 32   branch target of the last accepted branch
//   squash_q   out  1   instruction now in ID is an annulled delay slot
//   state_q    out  2   FSM state: 00 NORMAL, 01 DSLOT, 10 ANNUL
//------------------------------------------------------------------------------
module branch_condition_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic        stall,
    input  logic        id_is_bicc,
    input  logic [3:0]  id_cond,
    input  logic        id_annul,
    input  logic [21:0] id_disp22,
    input  logic [31:0] id_pc,
    input  logic [3:0]  psr_icc,
    input  logic        ex_setcc,
    input  logic [3:0]  ex_icc,
    output logic        taken_q,
    output logic [31:0] target_q,
    output logic        squash_q,
    output logic [1:0]  state_q
);

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        DSLOT  = 2'b01,
        ANNUL  = 2'b10
    } state_t;

    logic [3:0]  effIcc;
    logic        flagZ;
    logic        flagC;
    logic        flagN;
    logic        flagV;
    logic        condBase;
    logic        condTrue;
    logic        isBranchAlways;
    logic        annulBranch;
    logic        accepted;
    logic [31:0] dispBytes;
    logic [31:0] branchTarget;
    state_t      stateD;
    logic        takenD;
    logic [31:0] targetD;
    logic        squashD;

    // The flags being written by the instruction in EX are newer than the PSR
    // copy, so they take precedence.
    assign effIcc = ex_setcc ? ex_icc : psr_icc;
    assign flagZ  = effIcc[3];
    assign flagC  = effIcc[2];
    assign flagN  = effIcc[1];
    assign flagV  = effIcc[0];

    // Each Bicc condition with cond[3]=1 is the complement of the one with
    // cond[3]=0. The low three bits choose the base test, and cond[3] inverts
    // it. BN (0000) and BA (1000) fall out as the constant 0 and its inverse.
    always_comb begin
        condBase = 1'b0;
        case (id_cond[2:0])
            3'b000:  condBase = 1'b0;
            3'b001:  condBase = flagZ;
            3'b010:  condBase = flagZ | (flagN ^ flagV);
            3'b011:  condBase = flagN ^ flagV;
            3'b100:  condBase = flagC | flagZ;
            3'b101:  condBase = flagC;
            3'b110:  condBase = flagN;
            3'b111:  condBase = flagV;
            default: condBase = 1'b0;
        endcase
    end

    assign condTrue = condBase ^ id_cond[3];

    // The displacement counts words. Sign-extend it and scale it to bytes.
    // Wrap-around past 2^32 is intended, so nothing is flagged on it.
    assign dispBytes    = {{8{id_disp22[21]}}, id_disp22, 2'b00};
    assign branchTarget = id_pc + dispBytes;

    // A Bicc in ID is ignored while it is itself the annulled delay slot.
    assign accepted = id_is_bicc & ~stall & (state_q != ANNUL);

    // With a=1, BA annuls its delay slot even though it is taken. Every other
    // condition annuls only when it is not taken, and that includes BN.
    assign isBranchAlways = (id_cond == 4'b1000);
    assign annulBranch    = id_annul & (isBranchAlways | ~condTrue);

    // Next-state logic. From DSLOT, a Bicc in the delay slot (DCTI couple) is
    // accepted and its own transition wins over the return to NORMAL. The
    // illegal encoding 11 falls back to NORMAL.
    always_comb begin
        stateD = NORMAL;
        case (state_q)
            NORMAL, DSLOT: begin
                if (accepted) begin
                    stateD = annulBranch ? ANNUL : DSLOT;
                end else begin
                    stateD = NORMAL;
                end
            end
            ANNUL:   stateD = NORMAL;
            default: stateD = NORMAL;
        endcase
    end

    // taken drops back to 0 on every advancing edge without an accepted
    // branch. The target keeps the value of the last accepted branch.
    always_comb begin
        takenD  = accepted & condTrue;
        targetD = target_q;
        if (accepted) begin
            targetD = branchTarget;
        end
        squashD = (stateD == ANNUL);
    end

    // State register. clr takes priority over stall and over anything in
    // flight. stall freezes every register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= NORMAL;
            taken_q  <= 1'b0;
            target_q <= 32'h0000_0000;
            squash_q <= 1'b0;
        end else if (!stall) begin
            state_q  <= stateD;
            taken_q  <= takenD;
            target_q <= targetD;
            squash_q <= squashD;
        end
    end

endmodule

// File: tb/tb_branch_condition_unit.sv
//------------------------------------------------------------------------------
// tb_branch_condition_unit
//
// Purpose:
//   Drives branch_condition_unit with directed and random stimulus. A
//   behavioural model predicts the registered outputs for each edge, and the
//   prediction goes into a queue. A monitor on the falling clock edge pops
//   each prediction and compares it with the DUT outputs.
//------------------------------------------------------------------------------
module tb_branch_condition_unit;

    logic        clk;
    logic        clr;
    logic        stall;
    logic        id_is_bicc;
    logic [3:0]  id_cond;
    logic        id_annul;
    logic [21:0] id_disp22;
    logic [31:0] id_pc;
    logic [3:0]  psr_icc;
    logic        ex_setcc;
    logic [3:0]  ex_icc;
    logic        taken_q;
    logic [31:0] target_q;
    logic        squash_q;
    logic [1:0]  state_q;

    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic        squash;
        logic [1:0]  state;
    } expect_t;

    expect_t expQ[$];

    int checkCount = 0;
    int errorCount = 0;

    // Model state: 0 = normal flow, 1 = in delay slot, 2 = annulled slot.
    int          modelMode   = 0;
    logic        modelTaken  = 1'b0;
    logic [31:0] modelTarget = 32'h0;

    branch_condition_unit dut (
        .clk        (clk),
        .clr        (clr),
        .stall      (stall),
        .id_is_bicc (id_is_bicc),
        .id_cond    (id_cond),
        .id_annul   (id_annul),
        .id_disp22  (id_disp22),
        .id_pc      (id_pc),
        .psr_icc    (psr_icc),
        .ex_setcc   (ex_setcc),
        .ex_icc     (ex_icc),
        .taken_q    (taken_q),
        .target_q   (target_q),
        .squash_q   (squash_q),
        .state_q    (state_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The Bicc condition table, written out one condition at a time.
    function automatic bit condHolds(input logic [3:0] c, input logic [3:0] icc);
        bit z, cy, n, v;
        z  = icc[3];
        cy = icc[2];
        n  = icc[1];
        v  = icc[0];
        case (c)
            4'b1000: return 1'b1;
            4'b0000: return 1'b0;
            4'b1001: return !z;
            4'b0001: return z;
            4'b1010: return !(z || (n != v));
            4'b0010: return z || (n != v);
            4'b1011: return !(n != v);
            4'b0011: return n != v;
            4'b1100: return !(cy || z);
            4'b0100: return cy || z;
            4'b1101: return !cy;
            4'b0101: return cy;
            4'b1110: return !n;
            4'b0110: return n;
            4'b1111: return !v;
            default: return v;
        endcase
    endfunction

    // Advances the model by one clock edge.
    function automatic void modelStep();
        logic [3:0]  icc;
        bit          isAccepted;
        bit          result;
        bit          annulIt;
        int          dispWords;
        logic [31:0] tgt;
        if (clr) begin
            modelMode   = 0;
            modelTaken  = 1'b0;
            modelTarget = 32'h0;
        end else if (!stall) begin
            icc        = ex_setcc ? ex_icc : psr_icc;
            isAccepted = id_is_bicc && (modelMode != 2);
            result     = condHolds(id_cond, icc);
            annulIt    = id_annul && ((id_cond == 4'b1000) || !result);
            dispWords  = id_disp22[21] ? int'(id_disp22) - (1 << 22) : int'(id_disp22);
            tgt        = id_pc + 32'(dispWords * 4);
            modelTaken = isAccepted && result;
            if (isAccepted) begin
                modelTarget = tgt;
                modelMode   = annulIt ? 2 : 1;
            end else begin
                modelMode = 0;
            end
        end
    endfunction

    // Drives one cycle of inputs just after the falling edge, then queues the
    // outputs expected after the next rising edge.
    task automatic applyStimulus(
        input logic        aClr,
        input logic        aStall,
        input logic        aBicc,
        input logic [3:0]  aCond,
        input logic        aAnnul,
        input logic [21:0] aDisp,
        input logic [31:0] aPc,
        input logic [3:0]  aPsr,
        input logic        aSetcc,
        input logic [3:0]  aExIcc
    );
        expect_t e;
        @(negedge clk);
        #1;
        clr        = aClr;
        stall      = aStall;
        id_is_bicc = aBicc;
        id_cond    = aCond;
        id_annul   = aAnnul;
        id_disp22  = aDisp;
        id_pc      = aPc;
        psr_icc    = aPsr;
        ex_setcc   = aSetcc;
        ex_icc     = aExIcc;
        modelStep();
        e.taken  = modelTaken;
        e.target = modelTarget;
        e.squash = (modelMode == 2);
        e.state  = 2'(modelMode);
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each clock cycle produces an output word, so one prediction is
    // consumed per falling edge whenever a prediction is waiting.
    always @(negedge clk) begin
        expect_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("taken_q",  32'(taken_q),  32'(e.taken));
            checkOutput("target_q", target_q,      e.target);
            checkOutput("squash_q", 32'(squash_q), 32'(e.squash));
            checkOutput("state_q",  32'(state_q),  32'(e.state));
        end
    end

    // Idle cycle with no branch in ID.
    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 22'h0, 32'h0, 4'h0, 1'b0, 4'h0);
    endtask

    initial begin
        int waitCycles;
        clr        = 1'b1;
        stall      = 1'b0;
        id_is_bicc = 1'b0;
        id_cond    = 4'h0;
        id_annul   = 1'b0;
        id_disp22  = 22'h0;
        id_pc      = 32'h0;
        psr_icc    = 4'h0;
        ex_setcc   = 1'b0;
        ex_icc     = 4'h0;

        // Reset, with stall also set to show that clr beats it.
        applyStimulus(1'b1, 1'b1, 1'b1, 4'h8, 1'b1, 22'h5, 32'h40, 4'h0, 1'b0, 4'h0);
        idleCycle();

        // BE with Z=1 from the PSR: taken, target 0x110, then DSLOT.
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 22'd4, 32'h100, 4'b1000, 1'b0, 4'h0);
        idleCycle();

        // BE where the forwarded EX flags clear Z: not taken.
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 22'd4, 32'h200, 4'b1000, 1'b1, 4'b0000);
        idleCycle();

        // BNE,a with Z=1 annuls the slot. A Bicc in the slot is ignored.
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b1001, 1'b1, 22'd8, 32'h300, 4'b1000, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b1000, 1'b0, 22'd1, 32'h304, 4'b0000, 1'b0, 4'h0);
        idleCycle();

        // BA,a backwards by one word from 0x4 wraps to 0x0.
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b1000, 1'b1, 22'h3FFFFF, 32'h4, 4'b0000, 1'b0, 4'h0);
        idleCycle();

        // DCTI couple: a Bicc in the delay slot is accepted.
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b1000, 1'b0, 22'd2, 32'h500, 4'b0000, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 22'd3, 32'h504, 4'b0000, 1'b0, 4'h0);
        idleCycle();

        // An accepted branch followed by three stalled cycles.
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0101, 1'b0, 22'h20, 32'h600, 4'b0100, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 4'b1000, 1'b0, 22'h7, 32'h700, 4'h0, 1'b0, 4'h0);
        end
        idleCycle();
        idleCycle();

        // clr during ANNUL with stall held.
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b1000, 1'b1, 22'h10, 32'h800, 4'b0000, 1'b0, 4'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'b1000, 1'b1, 22'h10, 32'h804, 4'b0000, 1'b0, 4'h0);
        idleCycle();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(
                1'($urandom_range(0, 49) == 0),
                1'($urandom_range(0, 4) == 0),
                1'($urandom_range(0, 1)),
                4'($urandom),
                1'($urandom),
                22'($urandom),
                32'($urandom),
                4'($urandom),
                1'($urandom),
                4'($urandom)
            );
        end

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 20) begin
            @(posedge clk);
            waitCycles++;
        end
        if (expQ.size() > 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL drain: %0d predictions left, expected 0", expQ.size());
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/branch_condition_unit.md
BRANCH_CONDITION_UNIT -- requirements
Module: branch_condition_unit

Interface
REQ-001 SHALL have parameters (name, default, meaning): none; all widths are fixed.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port: clr  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: stall  input  1  pipeline hold; 1 = all registers keep their value.
REQ-005 SHALL have port: id_is_bicc  input  1  instruction in ID is a Bicc.
REQ-006 SHALL have port: id_cond  input  4  Bicc cond field.
REQ-007 SHALL have port: id_annul  input  1  Bicc a bit.
REQ-008 SHALL have port: id_disp22  input  22  Bicc displacement, in words.
REQ-009 SHALL have port: id_pc  input  32  PC of the ID instruction.
REQ-010 SHALL have port: psr_icc  input  4  condition flags from the PSR register: [3]=Z, [2]=C, [1]=N, [0]=V.
REQ-011 SHALL have port: ex_setcc  input  1  EX instruction writes icc this cycle.
REQ-012 SHALL have port: ex_icc  input  4  icc being produced in EX, same bit order as psr_icc.
REQ-013 SHALL have port: taken_q  output  1  registered branch-taken indication.
REQ-014 SHALL have port: target_q  output  32  registered branch target.
REQ-015 SHALL have port: squash_q  output  1  registered; 1 = instruction now in ID is an annulled delay slot.
REQ-016 SHALL have port: state_q  output  2  FSM state: 00 NORMAL, 01 DSLOT, 10 ANNUL.

Function
REQ-017 SHALL form effective flags eff = ex_setcc ? ex_icc : psr_icc (EX forwarding over the PSR value).
REQ-018 SHALL evaluate cond on eff per SPARC Bicc:
- 1000 BA = 1; 0000 BN = 0
- 1001 !Z; 0001 Z
- 1010 !(Z|(N^V)); 0010 Z|(N^V)
- 1011 !(N^V); 0011 N^V
- 1100 !(C|Z); 0100 C|Z
- 1101 !C; 0101 C
- 1110 !N; 0110 N
- 1111 !V; 0111 V
REQ-019 SHALL compute target = id_pc + (sign_extend(id_disp22) << 2), modulo 2^32; wrap-around is not flagged.
REQ-020 SHALL define an accepted branch as: id_is_bicc=1, stall=0 and state_q != ANNUL.
REQ-021 SHALL, one cycle after an accepted branch, present taken_q = cond result and target_q = target; latency is 1 cycle.
REQ-022 SHALL set taken_q=0 on every non-stalled edge without an accepted branch; target_q holds its last value.
REQ-023 SHALL decide annul on an accepted branch as: annul = id_annul & (cond is BA, or cond result = 0); this includes BN.
REQ-024 SHALL use the following FSM transitions, applied only on non-stalled edges:
- NORMAL, accepted branch -> ANNUL if annul, else DSLOT
- NORMAL, no branch -> NORMAL
- DSLOT -> NORMAL; if the delay-slot instruction is itself a Bicc, it is accepted and its transition is applied instead (DCTI couple)
- ANNUL -> NORMAL; the ID instruction is ignored, including when id_is_bicc=1
REQ-025 SHALL drive squash_q=1 exactly while state_q=ANNUL, and 0 otherwise.
REQ-026 SHALL hold taken_q, target_q, squash_q and state_q unchanged on any edge with stall=1.
REQ-027 SHALL treat the encoding state_q=11 as illegal and return to NORMAL on the next edge.

Reset
REQ-028 SHALL, on posedge clk with clr=1, set state_q=NORMAL, taken_q=0, squash_q=0 and target_q=0.
REQ-029 SHALL give clr priority over stall and over any branch in flight, including mid-DSLOT or mid-ANNUL.
REQ-030 SHALL produce outputs fully determined by the registers only; there is no combinational path from inputs to outputs.

Verification
REQ-031 SHALL cover: BE (0001), psr_icc=1000 (Z=1), ex_setcc=0, id_pc=0x100, disp22=4 -> next cycle taken_q=1, target_q=0x110, state_q=DSLOT.
REQ-032 SHALL cover: BE, psr_icc=1000, ex_setcc=1, ex_icc=0000 -> taken_q=0 (forwarded flags win).
REQ-033 SHALL cover: BNE (1001), a=1, Z=1 -> taken_q=0, squash_q=1 for one cycle; a following Bicc in ID during ANNUL produces no taken_q.
REQ-034 SHALL cover: BA, a=1, id_pc=0x0000_0004, disp22=0x3FFFFF -> taken_q=1, target_q=0x0000_0000, squash_q=1.
REQ-035 SHALL cover: accepted branch, then stall=1 for 3 cycles -> taken_q and state_q frozen for all 3 cycles; both advance on the first stall=0 edge.
REQ-036 SHALL cover: clr=1 while in ANNUL with stall=1 -> next edge gives state_q=NORMAL, squash_q=0, taken_q=0, target_q=0.
